// File: rtl/flash_sequencer.sv
// Blink-pattern sequencer for the wildfire-cube sprite: counts flash-counter ticks
// through NUM_FLASHES ON/OFF phase pairs and reports busy/done to the game controller.
module flash_sequencer #(
  parameter int PHASE_TICKS = 4,
  parameter int NUM_FLASHES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  output logic             flash,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] flashes_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST_PHASE = CNT_W'(PHASE_TICKS - 1);
  localparam logic [CNT_W-1:0] LP_NUM        = CNT_W'(NUM_FLASHES);
  localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] r_flashes_left;
  logic [CNT_W-1:0] w_flashes_nxt;
  logic             r_flash;
  logic             r_busy;
  logic             r_done;
  logic             w_flash_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_tick_last;

  assign w_tick_last = tick && (r_phase_cnt == LP_LAST_PHASE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_phase_cnt    <= '0;
      r_flashes_left <= '0;
      r_flash        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase_cnt    <= w_phase_nxt;
      r_flashes_left <= w_flashes_nxt;
      r_flash        <= w_flash_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
    end
  end

  // stop overrides every other input in every state
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = S_ON;
        S_ON:   if (w_tick_last) w_state_nxt = S_OFF;
        S_OFF: begin
          if (w_tick_last) begin
            w_state_nxt = (r_flashes_left == LP_ONE) ? S_DONE : S_ON;
          end
        end
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are computed from the upcoming state so they can be registered
  // and still appear in the same cycle as the state they describe.
  always_comb begin
    w_flash_nxt   = (w_state_nxt == S_ON);
    w_busy_nxt    = (w_state_nxt == S_ON) || (w_state_nxt == S_OFF);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_phase_nxt   = r_phase_cnt;
    w_flashes_nxt = r_flashes_left;

    if (w_state_nxt != r_state) begin
      w_phase_nxt = '0;
    end else if (tick && ((r_state == S_ON) || (r_state == S_OFF))) begin
      w_phase_nxt = r_phase_cnt + LP_ONE;
    end

    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE)) begin
      w_flashes_nxt = '0;
    end else if (r_state == S_IDLE) begin
      w_flashes_nxt = LP_NUM;
    end else if ((r_state == S_OFF) && (w_state_nxt == S_ON)) begin
      w_flashes_nxt = r_flashes_left - LP_ONE;
    end
  end

  assign flash        = r_flash;
  assign busy         = r_busy;
  assign done         = r_done;
  assign flashes_left = r_flashes_left;

endmodule
